// File: rtl/complex_accumulator.sv
// Frame-based complex accumulator: sums signed (re,im) beats with wrap-around,
// tracks a sticky overflow flag and presents the result until the consumer takes it.
module complex_accumulator #(
    parameter int W         = 8,
    parameter int ACC_W     = 10,
    parameter int MAX_TERMS = 16,
    localparam int CW       = $clog2(MAX_TERMS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*W-1:0]       in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [2*ACC_W-1:0]   out_data,
    output logic [CW-1:0]        out_count,
    output logic                 out_ovf,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                  r_state;
    logic signed [ACC_W-1:0] r_acc_re, r_acc_im;
    logic [CW-1:0]           r_count;
    logic                    r_ovf;

    logic signed [W-1:0]     w_in_re, w_in_im;
    logic signed [ACC_W-1:0] w_ext_re, w_ext_im;
    logic signed [ACC_W-1:0] w_sum_re, w_sum_im;
    logic                    w_ovf_re, w_ovf_im;
    logic                    w_accept, w_first, w_close;
    logic [CW-1:0]           w_cnt_nxt;

    assign w_in_re  = in_data[2*W-1:W];
    assign w_in_im  = in_data[W-1:0];
    assign w_ext_re = ACC_W'(w_in_re);
    assign w_ext_im = ACC_W'(w_in_im);
    assign w_sum_re = r_acc_re + w_ext_re;
    assign w_sum_im = r_acc_im + w_ext_im;

    // Signed overflow: operands agree in sign but the wrapped sum does not.
    assign w_ovf_re = (r_acc_re[ACC_W-1] == w_ext_re[ACC_W-1]) &&
                      (w_sum_re[ACC_W-1] != r_acc_re[ACC_W-1]);
    assign w_ovf_im = (r_acc_im[ACC_W-1] == w_ext_im[ACC_W-1]) &&
                      (w_sum_im[ACC_W-1] != r_acc_im[ACC_W-1]);

    assign w_accept  = in_valid && (r_state != HOLD);
    assign w_first   = (r_state == IDLE);
    assign w_cnt_nxt = w_first ? CW'(1) : r_count + CW'(1);
    assign w_close   = in_last || (w_cnt_nxt == CW'(MAX_TERMS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_acc_re <= '0;
            r_acc_im <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        if (w_first) begin
                            r_acc_re <= w_ext_re;
                            r_acc_im <= w_ext_im;
                            r_ovf    <= 1'b0;
                        end else begin
                            r_acc_re <= w_sum_re;
                            r_acc_im <= w_sum_im;
                            r_ovf    <= r_ovf | w_ovf_re | w_ovf_im;
                        end
                        r_count <= w_cnt_nxt;
                        r_state <= w_close ? HOLD : ACCUM;
                    end
                end
                HOLD:    if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Result registers double as the output hold stage; they only change on accepted beats.
    assign in_ready  = (r_state != HOLD);
    assign out_valid = (r_state == HOLD);
    assign out_data  = {r_acc_re, r_acc_im};
    assign out_count = r_count;
    assign out_ovf   = r_ovf;

endmodule

// File: doc/complex_accumulator.md
COMPLEX_ACCUMULATOR -- requirements
Module: complex_accumulator

Interface
- REQ-001 SHALL have parameter W, default 8: signed bit width of each component of an input complex word.
- REQ-002 SHALL have parameter ACC_W, default 10: signed bit width of each accumulator component; ACC_W >= W.
- REQ-003 SHALL have parameter MAX_TERMS, default 16: maximum number of terms in one frame; MAX_TERMS >= 1.
- REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
- REQ-005 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
- REQ-006 SHALL have port in_data, input, 2W: complex product from the multiply stage; real part in [2W-1:W], imaginary part in [W-1:0], both two's complement.
- REQ-007 SHALL have port in_valid, input, 1: in_data is valid this cycle.
- REQ-008 SHALL have port in_last, input, 1: current beat is the final term of the frame; sampled only on an accepted beat.
- REQ-009 SHALL have port in_ready, output, 1: the block can accept a beat this cycle.
- REQ-010 SHALL have port out_data, output, 2*ACC_W: accumulated sum; real part in [2*ACC_W-1:ACC_W], imaginary part in [ACC_W-1:0].
- REQ-011 SHALL have port out_count, output, clog2(MAX_TERMS+1): number of terms in the presented sum.
- REQ-012 SHALL have port out_ovf, output, 1: sticky flag, set if either component overflowed during the frame.
- REQ-013 SHALL have port out_valid, output, 1: the result is presented on out_data.
- REQ-014 SHALL have port out_ready, input, 1: the consumer accepts the result.

Function
- REQ-015 SHALL implement the FSM states IDLE, ACCUM and HOLD; all outputs are registered or decoded from state, with no combinational path from inputs to outputs.
- REQ-016 SHALL drive in_ready = 1 in IDLE and ACCUM and in_ready = 0 in HOLD; a beat is accepted only when in_valid && in_ready.
- REQ-017 SHALL, on a beat accepted in IDLE, load the accumulator with the sign-extended in_data (no add to prior contents), set the count to 1 and clear ovf.
- REQ-018 SHALL, on a beat accepted in ACCUM, add the sign-extended real and imaginary parts to the respective accumulator components and increment the count.
- REQ-019 SHALL compute each component addition modulo 2^ACC_W (wrap-around); ovf SHALL set when the two operand signs are equal and the result sign differs, and SHALL stay set until the next frame starts.
- REQ-020 SHALL close the frame on an accepted beat with in_last = 1, or on the accepted beat that brings the count to MAX_TERMS; the next state is then HOLD, otherwise ACCUM.
- REQ-021 SHALL hold state in IDLE and ACCUM when no beat is accepted; an ACCUM frame waits indefinitely, with no timeout.
- REQ-022 SHALL assert out_valid only in HOLD, entered the cycle after the closing beat (latency 1 cycle); out_data, out_count and out_ovf SHALL remain stable while out_valid = 1.
- REQ-023 SHALL go from HOLD to IDLE in the cycle after out_valid && out_ready; no input beat is accepted in that HOLD cycle, so a new frame starts no earlier than the following cycle.
- REQ-024 SHALL ignore in_last when in_valid = 0, and SHALL ignore in_data when no beat is accepted.

Reset
- REQ-025 SHALL, when rst_n = 0 at a rising clk edge, enter IDLE and clear to 0 the accumulator, count, out_ovf and out_valid; in_ready SHALL be 1 after reset.
- REQ-026 SHALL, on reset mid-frame or in HOLD, discard the partial or pending result; it is never presented.

Verification
- REQ-027 SHALL cover: 4 beats (7,23),(14,-28),(14,-3),(-13,-104), last on beat 4, out_ready = 1 -> one cycle later out_valid = 1, out_data = (22,-112), out_count = 4, out_ovf = 0; IDLE on the next cycle.
- REQ-028 SHALL cover: a single beat (-5,3) with last = 1 -> out_data = (-5,3), out_count = 1.
- REQ-029 SHALL cover: 5 beats (127,0), last on beat 5, ACC_W = 10 -> out_data = (-389,0), out_ovf = 1; the next frame of (1,1) with last -> out_ovf = 0.
- REQ-030 SHALL cover: 16 beats (1,-1), in_last never asserted -> the frame closes on beat 16, out_count = 16, out_data = (16,-16).
- REQ-031 SHALL cover: a result held with out_ready = 0 for 3 cycles while in_valid = 1 -> out_data stable, in_ready = 0, no beat consumed; the first beat is accepted 2 cycles after out_ready rises.
- REQ-032 SHALL cover: rst_n = 0 for one cycle after 2 of 3 beats -> out_valid never asserts for that frame; a fresh frame (2,2) with last -> out_data = (2,2), out_count = 1.
